// File: rtl/interp_point_fetch.sv
// Point-table fetch for piecewise-linear interpolation: loads strictly increasing
// (x,y) points, then for each query finds the bracketing segment and issues it downstream.
module interp_point_fetch #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tbl_clear,
  input  logic                        ld_valid,
  input  logic [DATA_WIDTH/2-1:0]     ld_x,
  input  logic [DATA_WIDTH/2-1:0]     ld_y,
  output logic                        ld_ready,
  output logic                        ld_err,
  input  logic                        q_valid,
  input  logic [DATA_WIDTH/2-1:0]     q_x,
  output logic                        q_ready,
  output logic [DATA_WIDTH-1:0]       x0,
  output logic [DATA_WIDTH-1:0]       x1,
  output logic [DATA_WIDTH/2-1:0]     q_out,
  output logic                        interpolation_start,
  input  logic                        interpolation_done,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int unsigned HW = DATA_WIDTH / 2;
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_WAIT   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [IW-1:0]        i_q, i_d;
  logic [IW-1:0]        s_q, s_d;
  logic [HW-1:0]        q_out_q, q_out_d;
  logic [DATA_WIDTH-1:0] x0_q, x0_d;
  logic [DATA_WIDTH-1:0] x1_q, x1_d;
  logic                 start_q, start_d;
  logic                 ld_err_q, ld_err_d;

  // Point table: plain registers, never reset; count_q alone defines validity.
  logic [HW-1:0]        x_tbl [DEPTH];
  logic [HW-1:0]        y_tbl [DEPTH];

  logic                 is_idle;
  logic                 q_ready_c;
  logic                 q_accept_c;
  logic                 tbl_we_c;
  logic [IW-1:0]        last_idx_c;
  logic [IW-1:0]        s_next_c;
  logic                 ld_full_c;
  logic                 ld_order_bad_c;

  assign is_idle        = (state_q == ST_IDLE);
  assign q_ready_c      = is_idle && (count_q >= CW'(2));
  assign q_accept_c     = q_valid && q_ready_c;
  assign last_idx_c     = IW'(count_q - CW'(1));
  assign s_next_c       = IW'(s_q + IW'(1));
  assign ld_full_c      = (count_q == CW'(DEPTH));
  assign ld_order_bad_c = (count_q != CW'(0)) && (ld_x <= x_tbl[last_idx_c]);

  // Next-state and datapath decisions.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    i_d      = i_q;
    s_d      = s_q;
    q_out_d  = q_out_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    start_d  = 1'b0;
    ld_err_d = 1'b0;
    tbl_we_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A query wins over both clear and load in the same cycle.
        if (q_accept_c) begin
          q_out_d = q_x;
          i_d     = IW'(1);
          state_d = ST_SEARCH;
        end else if (tbl_clear) begin
          count_d = '0;
        end else if (ld_valid) begin
          if (ld_full_c || ld_order_bad_c) begin
            ld_err_d = 1'b1;
          end else begin
            tbl_we_c = 1'b1;
            count_d  = count_q + CW'(1);
          end
        end
      end
      ST_SEARCH: begin
        // Exact match on X[i] keeps scanning so it lands in the segment starting at i.
        if ((q_out_q < x_tbl[i_q]) || (i_q == last_idx_c)) begin
          s_d     = IW'(i_q - IW'(1));
          state_d = ST_ISSUE;
        end else begin
          i_d = IW'(i_q + IW'(1));
        end
      end
      ST_ISSUE: begin
        x0_d    = {x_tbl[s_q], y_tbl[s_q]};
        x1_d    = {x_tbl[s_next_c], y_tbl[s_next_c]};
        start_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (interpolation_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      i_q      <= '0;
      s_q      <= '0;
      q_out_q  <= '0;
      x0_q     <= '0;
      x1_q     <= '0;
      start_q  <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      i_q      <= i_d;
      s_q      <= s_d;
      q_out_q  <= q_out_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      start_q  <= start_d;
      ld_err_q <= ld_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tbl_we_c) begin
      x_tbl[IW'(count_q)] <= ld_x;
      y_tbl[IW'(count_q)] <= ld_y;
    end
  end

  assign ld_ready            = is_idle && !q_accept_c;
  assign q_ready             = q_ready_c;
  assign ld_err              = ld_err_q;
  assign x0                  = x0_q;
  assign x1                  = x1_q;
  assign q_out               = q_out_q;
  assign interpolation_start = start_q;
  assign count               = count_q;

endmodule

// File: tb/tb_interp_point_fetch.sv
// Directed bench for interp_point_fetch: loads, segment search, handshakes and reset abort.
module tb_interp_point_fetch;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         tbl_clear = 1'b0;
  logic         ld_valid = 1'b0;
  logic [63:0]  ld_x = '0;
  logic [63:0]  ld_y = '0;
  logic         ld_ready;
  logic         ld_err;
  logic         q_valid = 1'b0;
  logic [63:0]  q_x = '0;
  logic         q_ready;
  logic [127:0] x0;
  logic [127:0] x1;
  logic [63:0]  q_out;
  logic         interpolation_start;
  logic         interpolation_done = 1'b0;
  logic [4:0]   count;

  int pass_cnt = 0;
  int total_cnt = 0;

  interp_point_fetch dut (
    .clk                 (clk),
    .reset               (reset),
    .tbl_clear           (tbl_clear),
    .ld_valid            (ld_valid),
    .ld_x                (ld_x),
    .ld_y                (ld_y),
    .ld_ready            (ld_ready),
    .ld_err              (ld_err),
    .q_valid             (q_valid),
    .q_x                 (q_x),
    .q_ready             (q_ready),
    .x0                  (x0),
    .x1                  (x1),
    .q_out               (q_out),
    .interpolation_start (interpolation_start),
    .interpolation_done  (interpolation_done),
    .count               (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [63:0] x, input logic [63:0] y);
    ld_valid = 1'b1; ld_x = x; ld_y = y;
    step();
    ld_valid = 1'b0;
  endtask

  task automatic query_accept(input logic [63:0] qx);
    q_valid = 1'b1; q_x = qx;
    step();
    q_valid = 1'b0;
  endtask

  // Counts edges from the accept edge until interpolation_start is seen.
  task automatic wait_issue(input string tag, input int n_exp,
                            input logic [127:0] e_x0, input logic [127:0] e_x1,
                            input logic [63:0] e_q);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 40) begin
      step();
      n++;
      seen = interpolation_start;
    end
    chk({tag, "_latency"}, 128'(n), 128'(n_exp));
    chk({tag, "_x0"}, x0, e_x0);
    chk({tag, "_x1"}, x1, e_x1);
    chk({tag, "_qout"}, 128'(q_out), 128'(e_q));
  endtask

  task automatic done_pulse();
    interpolation_done = 1'b1;
    step();
    interpolation_done = 1'b0;
  endtask

  function automatic logic [127:0] pt(input logic [63:0] x, input logic [63:0] y);
    return {x, y};
  endfunction

  initial begin
    bit seen_start;
    // Reset state
    #2;
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_x0", x0, 128'd0);
    chk("rst_x1", x1, 128'd0);
    chk("rst_qout", 128'(q_out), 128'd0);
    chk("rst_start", 128'(interpolation_start), 128'd0);
    chk("rst_lderr", 128'(ld_err), 128'd0);
    chk("rst_ldready", 128'(ld_ready), 128'd1);
    chk("rst_qready", 128'(q_ready), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Base table (0,0),(10,100),(20,400)
    load(64'd0, 64'd0);
    chk("ld1_qready", 128'(q_ready), 128'd0);
    load(64'd10, 64'd100);
    chk("ld2_qready", 128'(q_ready), 128'd1);
    load(64'd20, 64'd400);
    chk("ld3_count", 128'(count), 128'd3);
    chk("ld3_err", 128'(ld_err), 128'd0);

    // q=15: two SEARCH cycles, segment 1; then a long WAIT with done low
    query_accept(64'd15);
    wait_issue("q15", 3, pt(64'd10, 64'd100), pt(64'd20, 64'd400), 64'd15);
    ld_valid = 1'b1; ld_x = 64'd30; ld_y = 64'd1;
    for (int c = 0; c < 20; c++) begin
      if (c == 0) chk("wait_ldready", 128'(ld_ready), 128'd0);
      step();
      if (c == 0) chk("start_one_cycle", 128'(interpolation_start), 128'd0);
    end
    ld_valid = 1'b0;
    chk("wait_x0_stable", x0, pt(64'd10, 64'd100));
    chk("wait_x1_stable", x1, pt(64'd20, 64'd400));
    chk("wait_qready", 128'(q_ready), 128'd0);
    chk("wait_count", 128'(count), 128'd3);
    chk("wait_lderr", 128'(ld_err), 128'd0);
    done_pulse();
    chk("done_idle_qready", 128'(q_ready), 128'd1);

    // Below range, above range, exact match on interior point
    query_accept(64'd5);
    wait_issue("q5", 2, pt(64'd0, 64'd0), pt(64'd10, 64'd100), 64'd5);
    done_pulse();
    query_accept(64'd30);
    wait_issue("q30", 3, pt(64'd10, 64'd100), pt(64'd20, 64'd400), 64'd30);
    done_pulse();
    query_accept(64'd10);
    wait_issue("q10", 3, pt(64'd10, 64'd100), pt(64'd20, 64'd400), 64'd10);
    done_pulse();

    // Query and load together: query wins, load silently dropped
    q_valid = 1'b1; q_x = 64'd12;
    ld_valid = 1'b1; ld_x = 64'd30; ld_y = 64'd9;
    #1;
    chk("both_ldready", 128'(ld_ready), 128'd0);
    step();
    q_valid = 1'b0; ld_valid = 1'b0;
    chk("both_count", 128'(count), 128'd3);
    chk("both_lderr", 128'(ld_err), 128'd0);
    chk("both_qready", 128'(q_ready), 128'd0);
    wait_issue("q12", 3, pt(64'd10, 64'd100), pt(64'd20, 64'd400), 64'd12);
    done_pulse();

    // Clear beats a same-cycle load
    tbl_clear = 1'b1; ld_valid = 1'b1; ld_x = 64'd5; ld_y = 64'd5;
    step();
    tbl_clear = 1'b0; ld_valid = 1'b0;
    chk("clr_count", 128'(count), 128'd0);
    chk("clr_lderr", 128'(ld_err), 128'd0);

    // Duplicate x rejected
    load(64'd10, 64'd1);
    load(64'd10, 64'd2);
    chk("dup_lderr", 128'(ld_err), 128'd1);
    chk("dup_count", 128'(count), 128'd1);
    chk("dup_qready", 128'(q_ready), 128'd0);
    step();
    chk("dup_lderr_pulse", 128'(ld_err), 128'd0);

    // Fill to DEPTH, then overflow
    tbl_clear = 1'b1;
    step();
    tbl_clear = 1'b0;
    for (int k = 0; k < 16; k++) load(64'(k * 10), 64'(k));
    chk("full_count", 128'(count), 128'd16);
    chk("full_lderr0", 128'(ld_err), 128'd0);
    load(64'd1000, 64'd7);
    chk("ovf_lderr", 128'(ld_err), 128'd1);
    chk("ovf_count", 128'(count), 128'd16);

    // Above range on a full table: scans to the last index, segment 14
    query_accept(64'd155);
    wait_issue("q155", 16, pt(64'd140, 64'd14), pt(64'd150, 64'd15), 64'd155);
    done_pulse();

    // Reset in the middle of SEARCH aborts the query
    query_accept(64'd155);
    step(); step(); step();
    reset = 1'b1;
    #1;
    chk("abort_count", 128'(count), 128'd0);
    chk("abort_x0", x0, 128'd0);
    chk("abort_x1", x1, 128'd0);
    chk("abort_qout", 128'(q_out), 128'd0);
    chk("abort_start", 128'(interpolation_start), 128'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (interpolation_start) seen_start = 1'b1;
    end
    chk("abort_no_start", 128'(seen_start), 128'd0);
    chk("abort_qready", 128'(q_ready), 128'd0);
    load(64'd3, 64'd30);
    chk("reload1_qready", 128'(q_ready), 128'd0);
    load(64'd8, 64'd80);
    chk("reload2_qready", 128'(q_ready), 128'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/interp_point_fetch.md
INTERP_POINT_FETCH -- requirements
Module: interp_point_fetch

Interface
REQ-001 Parameter DATA_WIDTH, default 128, is the packed point width {x,y}; each half is DATA_WIDTH/2 = 64 bits, unsigned.
REQ-002 Parameter DEPTH, default 16, is the maximum number of table points; power of two, at least 4.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 tbl_clear  input  1  synchronous table clear; effective only in IDLE.
REQ-006 ld_valid  input  1  point-load strobe.
REQ-007 ld_x / ld_y  input  64 each  point coordinates.
REQ-008 ld_ready  output  1  high when a load is accepted (IDLE).
REQ-009 ld_err  output  1  one-cycle pulse on a rejected load.
REQ-010 q_valid  input  1  query request.
REQ-011 q_x  input  64  query abscissa.
REQ-012 q_ready  output  1  high only in IDLE with count >= 2.
REQ-013 x0 / x1  output  DATA_WIDTH each  bracketing points {x,y}; x in [127:64], y in [63:0].
REQ-014 q_out  output  64  registered copy of the accepted q_x.
REQ-015 interpolation_start  output  1  one-cycle pulse; x0, x1, q_out valid from this cycle until interpolation_done.
REQ-016 interpolation_done  input  1  downstream completion pulse.
REQ-017 count  output  log2(DEPTH)+1  number of stored points.

Function
REQ-018 States: IDLE, SEARCH, ISSUE, WAIT; 2-bit encoded; reset state IDLE.
REQ-019 Load: in IDLE, ld_valid high stores (ld_x, ld_y) at index count and increments count.
REQ-020 Loads are rejected, with ld_err pulsed and count unchanged, when count == DEPTH or when count > 0 and ld_x <= X[count-1] (strictly increasing x required).
REQ-021 tbl_clear in IDLE sets count to 0; it has priority over a same-cycle ld_valid, and it is ignored outside IDLE.
REQ-022 Query accept: q_valid && q_ready latches q_x into q_out, sets index i = 1, and moves to SEARCH.
REQ-023 When q_valid and ld_valid are both high in IDLE, the query is accepted and the load is ignored; ld_ready is low in that cycle and no ld_err is pulsed.
REQ-024 SEARCH evaluates one index per cycle: if q_out < X[i] or i == count-1, select segment s = i-1 and go to ISSUE; otherwise i <= i+1.
REQ-025 Below-range queries (q_x < X[0]) select s = 0; at-or-above X[count-1], s = count-2; the downstream extrapolates.
REQ-026 Exact match q_x == X[i] falls through to the next segment, so s = i, unless i == count-1.
REQ-027 ISSUE: register x0 = {X[s],Y[s]} and x1 = {X[s+1],Y[s+1]}, assert interpolation_start for exactly one cycle, go to WAIT.
REQ-028 WAIT: hold x0, x1, q_out stable; on interpolation_done go to IDLE. A done pulse in any other state is ignored.
REQ-029 Latency from accept to interpolation_start = k+1 cycles, where k = number of SEARCH cycles (1..count-1).
REQ-030 The table is register storage; its contents are not reset, and only count is reset.
REQ-031 ld_ready = (state == IDLE) && !q_valid_accept.
REQ-032 q_ready = (state == IDLE) && (count >= 2).

Reset
REQ-033 reset asserted: state = IDLE, count = 0, x0 = x1 = 0, q_out = 0, interpolation_start = 0, ld_err = 0, immediately and asynchronously.
REQ-034 Reset mid-SEARCH or mid-WAIT aborts the query without issuing interpolation_start; after release, q_ready stays low until two points are reloaded.

Verification
REQ-035 Load (0,0),(10,100),(20,400); query q_x = 15 -> after 2 SEARCH cycles, interpolation_start with x0 = {20'd... X=10,Y=100}, x1 = {X=20,Y=400}, q_out = 15.
REQ-036 Same table, q_x = 5 (s = 0) and q_x = 30 (s = 1, above range) -> x0/x1 = points 0/1 and 1/2 respectively; q_x = 10 -> segment 1.
REQ-037 Load x = 10 then x = 10 -> second load gives ld_err pulse, count = 1, q_ready stays low; load DEPTH points, then one more -> ld_err, count = DEPTH.
REQ-038 Issue a query, hold interpolation_done low for 20 cycles -> x0/x1 stable, q_ready low, loads not accepted; done pulse -> IDLE next cycle.
REQ-039 Assert reset during SEARCH -> no interpolation_start pulse, count = 0, all outputs zero; tbl_clear asserted with ld_valid -> count = 0.
REQ-040 q_valid and ld_valid high together in IDLE -> query accepted, count unchanged, ld_err low.
